// File: rtl/led_pixel_fetch_if.sv
// Buffer-read and pixel-stream signals between led_pixel_fetch and its neighbours.
// slave is the fetch block's view; master is the controller/buffer/serializer side.
interface led_pixel_fetch_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 7,
    parameter int unsigned PIX_WIDTH     = 6
);
    logic                      start;
    logic [PIX_WIDTH-1:0]      num_pixels;
    logic                      ren;
    logic [ADDRESS_WIDTH-1:0]  raddr;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      pixel_valid;
    logic                      pixel_ready;
    logic [3*DATA_WIDTH-1:0]   pixel_data;
    logic                      pixel_last;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start, num_pixels, rdata, pixel_ready,
        output ren, raddr, pixel_valid, pixel_data, pixel_last, busy, done
    );

    modport master (
        output start, num_pixels, rdata, pixel_ready,
        input  ren, raddr, pixel_valid, pixel_data, pixel_last, busy, done
    );
endinterface

// File: rtl/led_pixel_fetch.sv
// Streams one frame of RGB pixels out of a byte-wide pixel buffer: three reads
// per pixel, assembled MSB-first, presented with a valid/ready handshake.
module led_pixel_fetch #(
    parameter int unsigned MEMORY_SIZE   = 128,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = $clog2(MEMORY_SIZE)
) (
    input  logic               clk,
    input  logic               rst_n,
    led_pixel_fetch_if.slave   bus
);
    localparam int unsigned MAX_PIXELS = MEMORY_SIZE / 3;
    localparam int unsigned PIX_WIDTH  = $clog2(MAX_PIXELS + 1);
    localparam int unsigned PIX_BITS   = 3 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                   r_state, w_state;
    logic [1:0]               r_phase, w_phase;
    logic [PIX_WIDTH-1:0]     r_remain, w_remain;
    logic                     r_ren, w_ren;
    logic [ADDRESS_WIDTH-1:0] r_raddr, w_raddr;
    logic                     r_pixel_valid, w_pixel_valid;
    logic [PIX_BITS-1:0]      r_pixel_data, w_pixel_data;
    logic                     r_pixel_last, w_pixel_last;
    logic                     r_busy, w_busy;
    logic                     r_done, w_done;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_phase       <= 2'd0;
            r_remain      <= '0;
            r_ren         <= 1'b0;
            r_raddr       <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_last  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_phase       <= w_phase;
            r_remain      <= w_remain;
            r_ren         <= w_ren;
            r_raddr       <= w_raddr;
            r_pixel_valid <= w_pixel_valid;
            r_pixel_data  <= w_pixel_data;
            r_pixel_last  <= w_pixel_last;
            r_busy        <= w_busy;
            r_done        <= w_done;
        end
    end

    // Next state; read data lags ren by one cycle, so byte k lands in phase k+1
    always_comb begin
        w_state       = r_state;
        w_phase       = r_phase;
        w_remain      = r_remain;
        w_ren         = 1'b0;
        w_raddr       = r_raddr;
        w_pixel_valid = r_pixel_valid;
        w_pixel_data  = r_pixel_data;
        w_pixel_last  = r_pixel_last;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_pixels != '0) begin
                        w_remain = (bus.num_pixels > PIX_WIDTH'(MAX_PIXELS))
                                   ? PIX_WIDTH'(MAX_PIXELS) : bus.num_pixels;
                        w_raddr  = '0;
                        w_ren    = 1'b1;
                        w_phase  = 2'd0;
                        w_state  = S_FETCH;
                    end else begin
                        w_state  = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                w_phase = r_phase + 2'd1;
                if (r_phase == 2'd1) begin
                    w_pixel_data[PIX_BITS-1 -: DATA_WIDTH] = bus.rdata;
                end
                if (r_phase == 2'd2) begin
                    w_pixel_data[2*DATA_WIDTH-1 -: DATA_WIDTH] = bus.rdata;
                    w_state = S_FLUSH;
                end else begin
                    w_ren   = 1'b1;
                    w_raddr = r_raddr + ADDRESS_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                w_pixel_data[DATA_WIDTH-1:0] = bus.rdata;
                w_pixel_valid = 1'b1;
                w_pixel_last  = (r_remain == PIX_WIDTH'(1));
                w_state       = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.pixel_ready) begin
                    w_pixel_valid = 1'b0;
                    w_pixel_last  = 1'b0;
                    w_remain      = r_remain - PIX_WIDTH'(1);
                    if (r_remain > PIX_WIDTH'(1)) begin
                        w_ren   = 1'b1;
                        w_raddr = r_raddr + ADDRESS_WIDTH'(1);
                        w_phase = 2'd0;
                        w_state = S_FETCH;
                    end else begin
                        w_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
        w_done = (w_state == S_DONE);
    end

    assign bus.ren         = r_ren;
    assign bus.raddr       = r_raddr;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.pixel_data  = r_pixel_data;
    assign bus.pixel_last  = r_pixel_last;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_led_pixel_fetch.sv
// Bench for led_pixel_fetch: buffer model, expected-pixel scoreboard and directed frames.
module tb_led_pixel_fetch;
    localparam int unsigned MEM = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_xfer = 0;
    int   n_ren = 0;
    int   max_raddr = 0;
    bit   last_seen = 1'b0;
    int   t_last = 0;
    logic [7:0] mem [MEM];

    typedef struct {
        logic [23:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    led_pixel_fetch_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(7), .PIX_WIDTH(6)) bus ();

    led_pixel_fetch #(.MEMORY_SIZE(MEM), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffer model
    always @(posedge clk) if (bus.ren) bus.rdata <= mem[bus.raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops, hold-stability while stalled, done timing
    logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [23:0] p_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                check("hold_valid", 64'(bus.pixel_valid), 64'd1);
                check("hold_data", 64'(bus.pixel_data), 64'(p_data));
                check("hold_last", 64'(bus.pixel_last), 64'(p_last));
            end
            if (bus.ren) begin
                n_ren++;
                if (int'(bus.raddr) > max_raddr) max_raddr = int'(bus.raddr);
            end
            if (bus.pixel_valid && bus.pixel_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 64'(bus.pixel_data), 64'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel_data", 64'(bus.pixel_data), 64'(e.data));
                    check("pixel_last", 64'(bus.pixel_last), 64'(e.last));
                end
                if (bus.pixel_last) begin
                    last_seen = 1'b1;
                    t_last = cyc;
                end
            end
            if (bus.done) begin
                n_done++;
                if (last_seen) check("done_after_last", 64'(cyc - t_last), 64'd1);
                last_seen = 1'b0;
            end
            p_valid = bus.pixel_valid;
            p_ready = bus.pixel_ready;
            p_data  = bus.pixel_data;
            p_last  = bus.pixel_last;
        end
    end

    task automatic load_mem(input bit ramp);
        for (int i = 0; i < int'(MEM); i++)
            mem[i] = ramp ? 8'(i) : ((i < 6) ? 8'(8'h11 * (i + 1)) : 8'hEE);
    endtask

    task automatic push(input logic [23:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Leaves the bench just after edge 0 (the start-sampling edge)
    task automatic start_frame(input int n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_pixels = 6'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c0 = n_done;
        int k = 0;
        while (n_done == c0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(name, 64'(n_done != c0), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ren"},   64'(bus.ren), 64'd0);
        check({tag, "_raddr"}, 64'(bus.raddr), 64'd0);
        check({tag, "_valid"}, 64'(bus.pixel_valid), 64'd0);
        check({tag, "_data"},  64'(bus.pixel_data), 64'd0);
        check({tag, "_last"},  64'(bus.pixel_last), 64'd0);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, x0, r0, k;
        bus.start = 1'b0;
        bus.num_pixels = '0;
        bus.pixel_ready = 1'b1;
        load_mem(1'b0);
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;

        // Single pixel: read timing and first-pixel latency
        push(24'h112233, 1'b1);
        start_frame(1);
        @(negedge clk);
        check("c1_ren", 64'(bus.ren), 64'd1);
        check("c1_raddr", 64'(bus.raddr), 64'd0);
        check("c1_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("c2_ren", 64'(bus.ren), 64'd1);
        check("c2_raddr", 64'(bus.raddr), 64'd1);
        @(negedge clk);
        check("c3_ren", 64'(bus.ren), 64'd1);
        check("c3_raddr", 64'(bus.raddr), 64'd2);
        @(negedge clk);
        check("c4_ren", 64'(bus.ren), 64'd0);
        check("c4_valid", 64'(bus.pixel_valid), 64'd0);
        check("c4_raddr_hold", 64'(bus.raddr), 64'd2);
        @(negedge clk);
        check("c5_valid", 64'(bus.pixel_valid), 64'd1);
        @(negedge clk);
        check("c6_done", 64'(bus.done), 64'd1);
        check("c6_valid", 64'(bus.pixel_valid), 64'd0);
        @(negedge clk);
        check("c7_done", 64'(bus.done), 64'd0);
        check("c7_busy", 64'(bus.busy), 64'd0);

        // Two pixels, ready tied high
        push(24'h112233, 1'b0);
        push(24'h445566, 1'b1);
        start_frame(2);
        wait_done(40, "two_px_done");

        // Stall in PRESENT for ten cycles
        bus.pixel_ready = 1'b0;
        push(24'h112233, 1'b1);
        start_frame(1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.pixel_valid && k < 20);
        check("stall_valid_seen", 64'(bus.pixel_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_data", 64'(bus.pixel_data), 64'h112233);
            check("stall_ren", 64'(bus.ren), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.pixel_ready = 1'b1;
        wait_done(10, "stall_done");

        // Zero-pixel frame
        r0 = n_ren;
        start_frame(0);
        @(negedge clk);
        check("zero_busy1", 64'(bus.busy), 64'd1);
        check("zero_done1", 64'(bus.done), 64'd1);
        check("zero_ren1", 64'(bus.ren), 64'd0);
        @(negedge clk);
        check("zero_busy2", 64'(bus.busy), 64'd0);
        check("zero_done2", 64'(bus.done), 64'd0);
        @(posedge clk);
        check("zero_ren_count", 64'(n_ren - r0), 64'd0);

        // Oversized frame clamps to 42 pixels; start pulses mid-frame ignored
        load_mem(1'b1);
        for (int p = 0; p < 42; p++)
            push({8'(3*p), 8'(3*p+1), 8'(3*p+2)}, p == 41);
        max_raddr = 0;
        x0 = n_xfer;
        c0 = n_done;
        start_frame(50);
        k = 0;
        while (n_done == c0 && k < 1000) begin
            @(posedge clk); #1;
            k++;
            bus.pixel_ready = (k % 3 != 2);
            bus.start = (k % 17 == 0);
            bus.num_pixels = 6'd5;
        end
        bus.start = 1'b0;
        bus.pixel_ready = 1'b1;
        check("clamp_done", 64'(n_done != c0), 64'd1);
        check("clamp_count", 64'(n_xfer - x0), 64'd42);
        check("clamp_max_raddr", 64'(max_raddr), 64'd125);
        check("clamp_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);

        // Reset during the second pixel's fetch aborts the frame
        load_mem(1'b0);
        push(24'h112233, 1'b0);
        start_frame(3);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(exp_q.size() == 0 && bus.ren) && k < 40);
        check("abort_reached_fetch2", 64'(bus.ren), 64'd1);
        c0 = n_done;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("abort_no_done", 64'(n_done - c0), 64'd0);
        push(24'h112233, 1'b0);
        push(24'h445566, 1'b1);
        start_frame(2);
        @(negedge clk);
        check("restart_raddr", 64'(bus.raddr), 64'd0);
        check("restart_ren", 64'(bus.ren), 64'd1);
        wait_done(40, "restart_done");

        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
